// File: rtl/dm_arb_pkg.sv
// Shared types and sizes for the data-memory arbiter.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dm_arb_state_t;

  localparam int NUM_M     = 2;
  localparam int DM_ADDR_W = 16;
  localparam int DM_DATA_W = 32;

  function automatic logic [NUM_M-1:0] onehot2(input logic idx);
    onehot2 = idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dm_arbiter_rr_pick2.sv
// Two-way round-robin picker: among masked requests, a tie goes to the master that was not served last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] mask,
  output logic       valid,
  output logic       idx
);

  logic [1:0] eff;

  always_comb begin
    eff   = req & mask;
    valid = |eff;
    if (&eff) idx = ~last;
    else      idx = eff[1];
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-master round-robin sequencer in front of the data memory, one DM access per grant.
// Optional build macro DM_ARB_LOCK_EN adds m_lock so a master can keep the grant back-to-back.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DATA_W = DM_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             m_req,
  input  logic [1:0]             m_we,
  input  logic [1:0][ADDR_W-1:0] m_addr,
  input  logic [1:0][DATA_W-1:0] m_wdata,
`ifdef DM_ARB_LOCK_EN
  input  logic [1:0]             m_lock,
`endif
  output logic [1:0]             m_ack,
  output logic [1:0][DATA_W-1:0] m_rdata,
  output logic                   busy,
  output logic                   DM_enable,
  output logic                   DM_write,
  output logic [ADDR_W-1:0]      DM_address,
  output logic [DATA_W-1:0]      DM_in,
  input  logic [DATA_W-1:0]      DM_out,
  output dm_arb_state_t          state_dbg
);

  // Handshake: a master raises m_req with a stable payload and holds both until the
  // single-cycle m_ack; a request that is not granted simply waits, its payload ignored.

  dm_arb_state_t     state;
  logic              gnt;
  logic              we_q;
  logic              rr_last;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [1:0] pick_mask;
  logic       pick_valid;
  logic       pick_idx;
  logic       keep;
  logic       load;
  logic       sel;

  // In RESP the acked master still holds m_req, so only the other one is eligible.
  always_comb begin
    keep = 1'b0;
`ifdef DM_ARB_LOCK_EN
    keep = (state == RESP) && m_lock[gnt] && m_req[gnt];
`endif
    pick_mask = (state == RESP) ? onehot2(~gnt) : 2'b11;
    sel       = keep ? gnt : pick_idx;
    load      = ((state == IDLE) && pick_valid) ||
                ((state == RESP) && (keep || pick_valid));
  end

  rr_pick2 u_pick (
    .req   (m_req),
    .last  (rr_last),
    .mask  (pick_mask),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      we_q    <= 1'b0;
      rr_last <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      m_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            gnt     <= sel;
            we_q    <= m_we[sel];
            addr_q  <= m_addr[sel];
            wdata_q <= m_wdata[sel];
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (!we_q) m_rdata[gnt] <= DM_out;
          state <= RESP;
        end
        RESP: begin
          rr_last <= gnt;
          if (load) begin
            gnt     <= sel;
            we_q    <= m_we[sel];
            addr_q  <= m_addr[sel];
            wdata_q <= m_wdata[sel];
            state   <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // DM pins are pure decodes of the registered state, so reset silences them at once.
  assign DM_enable  = (state == ACCESS);
  assign DM_write   = (state == ACCESS) && we_q;
  assign DM_address = (state == ACCESS) ? addr_q  : '0;
  assign DM_in      = (state == ACCESS) ? wdata_q : '0;
  assign m_ack      = (state == RESP) ? onehot2(gnt) : 2'b00;
  assign busy       = (state == ACCESS) || (state == RESP);
  assign state_dbg  = state;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a small behavioural data memory attached to the DM pins.
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [1:0]         m_req;
  logic [1:0]         m_we;
  logic [1:0][AW-1:0] m_addr;
  logic [1:0][DW-1:0] m_wdata;
`ifdef DM_ARB_LOCK_EN
  logic [1:0]         m_lock;
`endif
  logic [1:0]         m_ack;
  logic [1:0][DW-1:0] m_rdata;
  logic               busy;
  logic               DM_enable;
  logic               DM_write;
  logic [AW-1:0]      DM_address;
  logic [DW-1:0]      DM_in;
  logic [DW-1:0]      DM_out;
  dm_arb_state_t      state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  dm_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .m_req      (m_req),
    .m_we       (m_we),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
`ifdef DM_ARB_LOCK_EN
    .m_lock     (m_lock),
`endif
    .m_ack      (m_ack),
    .m_rdata    (m_rdata),
    .busy       (busy),
    .DM_enable  (DM_enable),
    .DM_write   (DM_write),
    .DM_address (DM_address),
    .DM_in      (DM_in),
    .DM_out     (DM_out),
    .state_dbg  (state_dbg)
  );

  // Memory model: unwritten words read as 0xC0DE0000 | address.
  logic [DW-1:0] mem [0:255];
  bit   [255:0]  written;
  logic [7:0]    mem_a;

  assign mem_a  = DM_address[7:0];
  assign DM_out = written[mem_a] ? mem[mem_a] : (32'hC0DE_0000 | {24'h0, mem_a});

  always @(posedge clk) begin
    if (DM_enable && DM_write) begin
      mem[mem_a]     <= DM_in;
      written[mem_a] <= 1'b1;
    end
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_idle();
    m_req   = 2'b00;
    m_we    = 2'b00;
    m_addr  = '0;
    m_wdata = '0;
`ifdef DM_ARB_LOCK_EN
    m_lock  = 2'b00;
`endif
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic set_req(input int m, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
    m_we[m]    = we;
    m_addr[m]  = addr;
    m_wdata[m] = wdata;
    m_req[m]   = 1'b1;
  endtask

  task automatic release_req(input int m);
    @(posedge clk);
    #1 m_req[m] = 1'b0;
  endtask

  task automatic wait_ack(input int m, output int lat);
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m_ack[m]) begin
        lat = i;
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int acks0;
    int acks1;
    int n0;
    logic [1:0] exp_ack;
    logic [DW-1:0] exp_d;

    drive_idle();

    // 1: reset holds every output low regardless of requests
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_req = 2'($urandom_range(0, 3));
      m_we  = 2'($urandom_range(0, 3));
      m_addr[0] = 16'($urandom_range(0, 255));
      @(negedge clk);
      check("rst_ack", m_ack, 2'b00);
      check("rst_ctl", {busy, DM_enable, DM_write}, 3'b000);
      check("rst_addr_in", {DM_address, DM_in}, '0);
      check("rst_rdata", m_rdata, '0);
      check("rst_state", state_dbg, IDLE);
    end
    drive_idle();
    @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle_en_busy", {DM_enable, busy}, 2'b00);
    end

    // 2: single-master write then read-back
    @(posedge clk); #1;
    set_req(0, 1'b1, 16'h0010, 32'hDEAD_BEEF);
    @(negedge clk);
    check("t2_still_idle", busy, 1'b0);
    @(negedge clk);
    check("t2_acc_ctl", {DM_enable, DM_write, busy}, 3'b111);
    check("t2_acc_addr", DM_address, 16'h0010);
    check("t2_acc_din", DM_in, 32'hDEAD_BEEF);
    check("t2_acc_noack", m_ack, 2'b00);
    @(negedge clk);
    check("t2_resp_ack", m_ack, 2'b01);
    check("t2_resp_dm_off", {DM_enable, DM_write}, 2'b00);
    release_req(0);
    @(negedge clk);
    check("t2_ack_pulse", m_ack, 2'b00);
    @(posedge clk); #1;
    set_req(0, 1'b0, 16'h0010, 32'h0);
    wait_ack(0, lat);
    check("t2_rd_latency", lat, 2);
    check("t2_rdata0", m_rdata[0], 32'hDEAD_BEEF);
    check("t2_rdata1", m_rdata[1], 32'h0);
    release_req(0);

    // 3: simultaneous requests after reset, master 0 first
    do_reset();
    set_req(0, 1'b1, 16'h0030, 32'h1111_2222);
    set_req(1, 1'b0, 16'h0010, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("t3_ack_c%0d", i), m_ack, (i == 2) ? 2'b01 : (i == 4) ? 2'b10 : 2'b00);
      if (i == 1) check("t3_m0_access", {DM_enable, DM_write, DM_address}, {2'b11, 16'h0030});
      if (i == 3) check("t3_m1_access", {DM_enable, DM_write, DM_address}, {2'b10, 16'h0010});
      if (i == 2) release_req(0);
      if (i == 4) release_req(1);
    end
    check("t3_rdata1", m_rdata[1], 32'hDEAD_BEEF);

    // 4: continuous contention alternates grants every two cycles
    do_reset();
    for (int g = 0; g < 4; g++) begin
      exp_q.push_back(32'hC0DE_0001);
      exp_q.push_back(32'hC0DE_0002);
    end
    set_req(0, 1'b0, 16'h0001, 32'h0);
    set_req(1, 1'b0, 16'h0002, 32'h0);
    acks0 = 0;
    acks1 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      exp_ack = (i >= 2 && i <= 16 && (i % 2) == 0) ? (((i / 2) % 2) == 1 ? 2'b01 : 2'b10) : 2'b00;
      check($sformatf("t4_ack_c%0d", i), m_ack, exp_ack);
      if (m_ack != 2'b00) begin
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        if (m_ack[0]) check("t4_rdata0", m_rdata[0], exp_d);
        else          check("t4_rdata1", m_rdata[1], exp_d);
        if (m_ack[0]) acks0++;
        if (m_ack[1]) acks1++;
        if (m_ack[0] && acks0 == 4) release_req(0);
        else if (m_ack[1] && acks1 == 4) release_req(1);
      end
    end
    check("t4_queue_empty", exp_q.size(), 0);

    // 5: reset during an ACCESS aborts the write
    do_reset();
    set_req(1, 1'b1, 16'h0020, 32'h1234_5678);
    @(negedge clk);
    @(negedge clk);
    check("t5_in_access", {DM_enable, DM_write, DM_address}, {2'b11, 16'h0020});
    #1 rst = 1'b0;
    #1;
    check("t5_async_drop", {DM_enable, DM_write, busy}, 3'b000);
    check("t5_no_ack", m_ack, 2'b00);
    drive_idle();
    @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_never_acked", m_ack, 2'b00);
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 16'h0020, 32'h0);
    wait_ack(0, lat);
    check("t5_rd_latency", lat, 2);
    check("t5_old_value", m_rdata[0], 32'hC0DE_0020);
    release_req(0);

`ifdef DM_ARB_LOCK_EN
    // 6: locked master keeps the grant for three reads, then master 1 gets in
    do_reset();
    m_lock[0] = 1'b1;
    set_req(0, 1'b0, 16'h0000, 32'h0);
    set_req(1, 1'b0, 16'h0002, 32'h0);
    n0 = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check($sformatf("t6_ack_c%0d", i), m_ack,
            (i == 2 || i == 4 || i == 6) ? 2'b01 : (i == 8) ? 2'b10 : 2'b00);
      if (m_ack[0]) begin
        check("t6_rdata0", m_rdata[0], 32'hC0DE_0000 | 32'(n0));
        n0++;
        if (n0 < 3) begin
          m_addr[0] = 16'(n0);
        end else begin
          m_lock[0] = 1'b0;
          m_req[0]  = 1'b0;
        end
      end
      if (m_ack[1]) begin
        check("t6_rdata1", m_rdata[1], 32'hC0DE_0002);
        release_req(1);
      end
    end
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
